// File: rtl/mac_wv_sequencer.sv
// Write-verify sequencer for a single memory cell: read, compare against target,
// apply set/reset pulses on a word-line voltage ramp until within tolerance or a limit is hit.
module mac_wv_sequencer #(
   parameter int unsigned MAX_ITER = 16,
   parameter int unsigned TOL      = 2,
   parameter logic [7:0]  V_START  = 8'd40,
   parameter logic [7:0]  V_STEP   = 8'd4,
   parameter logic [7:0]  V_MAX    = 8'd200,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [9:0] req_addr,
   input  logic [7:0] req_target,
   output logic       work_en,
   output logic       work_mode,
   output logic       op_mode,
   output logic [9:0] addr_out,
   output logic [7:0] v_wl,
   input  logic       work_down,
   input  logic [7:0] i_read,
   output logic       busy,
   output logic       done,
   output logic [1:0] status,
   output logic [4:0] iter_cnt
);
   localparam int WCW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, CHECK, PG_ISSUE, PG_WAIT, FIN} state_t;

   state_t         state_q, state_d;
   logic [9:0]     addr_q, addr_d;
   logic [7:0]     tgt_q, tgt_d;
   logic [7:0]     rd_q, rd_d;
   logic [7:0]     v_q, v_d;
   logic           mode_q, mode_d;
   logic           op_q, op_d;
   logic           ramp_q, ramp_d;
   logic [1:0]     status_q, status_d;
   logic [4:0]     iter_q, iter_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;

   logic signed [8:0] err;
   logic [8:0]        abs_err;
   logic              pol_set, same_pol, tmo;
   logic [8:0]        v_sum;
   logic [7:0]        v_next;

   assign err      = $signed({1'b0, rd_q}) - $signed({1'b0, tgt_q});
   assign abs_err  = err[8] ? $unsigned(-err) : $unsigned(err);
   assign pol_set  = (rd_q < tgt_q);
   assign same_pol = ramp_q && (op_q == pol_set);
   assign v_sum    = {1'b0, v_q} + {1'b0, V_STEP};
   assign v_next   = (v_sum > {1'b0, V_MAX}) ? V_MAX : v_sum[7:0];
   // Counter clears on issue, so this fires such that FIN lands TIMEOUT cycles after the issue.
   assign tmo      = (wcnt_q == WCW'(TIMEOUT - 2));

   assign req_ready = (state_q == IDLE);
   assign busy      = !req_ready;
   assign work_en   = (state_q == RD_ISSUE) || (state_q == PG_ISSUE);
   assign done      = (state_q == FIN);
   assign work_mode = mode_q;
   assign op_mode   = op_q;
   assign addr_out  = addr_q;
   assign v_wl      = v_q;
   assign status    = status_q;
   assign iter_cnt  = iter_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      tgt_d    = tgt_q;
      rd_d     = rd_q;
      v_d      = v_q;
      mode_d   = mode_q;
      op_d     = op_q;
      ramp_d   = ramp_q;
      status_d = status_q;
      iter_d   = iter_q;
      wcnt_d   = wcnt_q;
      case (state_q)
         IDLE: if (req_valid) begin
            addr_d   = req_addr;
            tgt_d    = req_target;
            iter_d   = '0;
            ramp_d   = 1'b0;
            status_d = 2'b00;
            mode_d   = 1'b0;
            state_d  = RD_ISSUE;
         end
         RD_ISSUE: begin
            wcnt_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (work_down) begin
               rd_d    = i_read;
               state_d = CHECK;
            end else if (tmo) begin
               status_d = 2'b11;
               state_d  = FIN;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         CHECK: begin
            if (abs_err <= 9'(TOL)) begin
               status_d = 2'b00;
               state_d  = FIN;
            end else if (iter_q == 5'(MAX_ITER)) begin
               status_d = 2'b01;
               state_d  = FIN;
            end else if (same_pol && (v_q == V_MAX)) begin
               status_d = 2'b10;
               state_d  = FIN;
            end else begin
               op_d    = pol_set;
               v_d     = same_pol ? v_next : V_START;
               ramp_d  = 1'b1;
               mode_d  = 1'b1;
               state_d = PG_ISSUE;
            end
         end
         PG_ISSUE: begin
            iter_d  = iter_q + 5'd1;
            wcnt_d  = '0;
            state_d = PG_WAIT;
         end
         PG_WAIT: begin
            if (work_down) begin
               mode_d  = 1'b0;
               state_d = RD_ISSUE;
            end else if (tmo) begin
               status_d = 2'b11;
               state_d  = FIN;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         tgt_q    <= '0;
         rd_q     <= '0;
         v_q      <= '0;
         mode_q   <= 1'b0;
         op_q     <= 1'b0;
         ramp_q   <= 1'b0;
         status_q <= 2'b00;
         iter_q   <= '0;
         wcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         tgt_q    <= tgt_d;
         rd_q     <= rd_d;
         v_q      <= v_d;
         mode_q   <= mode_d;
         op_q     <= op_d;
         ramp_q   <= ramp_d;
         status_q <= status_d;
         iter_q   <= iter_d;
         wcnt_q   <= wcnt_d;
      end
   end
endmodule

// File: tb/tb_mac_wv_sequencer.sv
// Scoreboarded bench: a macro model answers reads from a scripted read sequence, a reference
// model predicts every command and the final status, and a monitor compares as events appear.
module tb_mac_wv_sequencer;
   localparam int TIMEOUT = 1024, MAX_ITER = 16, TOL = 2;
   localparam int V_START = 40, V_STEP = 4, V_MAX = 200, V_MAX2 = 60;

   logic       sys_clk = 1'b0, sys_rst = 1'b1;
   logic       req_valid = 1'b0, req_ready;
   logic [9:0] req_addr = '0, addr_out;
   logic [7:0] req_target = '0, v_wl, i_read = '0;
   logic       work_en, work_mode, op_mode, work_down = 1'b0, busy, done;
   logic [1:0] status;
   logic [4:0] iter_cnt;

   logic       req_valid2 = 1'b0, req_ready2, work_en2, work_mode2, op_mode2, work_down2 = 1'b0;
   logic       busy2, done2;
   logic [9:0] addr_out2;
   logic [7:0] v_wl2;
   logic [1:0] status2;
   logic [4:0] iter_cnt2;

   mac_wv_sequencer dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_target(req_target), .work_en(work_en), .work_mode(work_mode),
      .op_mode(op_mode), .addr_out(addr_out), .v_wl(v_wl), .work_down(work_down),
      .i_read(i_read), .busy(busy), .done(done), .status(status), .iter_cnt(iter_cnt));

   mac_wv_sequencer #(.V_MAX(8'd60)) dut2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_addr(10'd5), .req_target(8'd100), .work_en(work_en2), .work_mode(work_mode2),
      .op_mode(op_mode2), .addr_out(addr_out2), .v_wl(v_wl2), .work_down(work_down2),
      .i_read(8'd0), .busy(busy2), .done(done2), .status(status2), .iter_cnt(iter_cnt2));

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct { int kind; int op; int v; int addr; int st; int it; } ev_t;
   ev_t expq[$];
   int  rdq[$];
   int  v2q[$];
   int  n_chk = 0, n_pass = 0;
   bit  noresp = 1'b0;
   int  pg_extra = 0;
   int  last_rd_cyc = 0;
   bit  prev_en = 1'b0;

   function automatic void chk(string nm, bit ok, int act, int ex);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ex);
   endfunction

   function automatic ev_t mk(int kind, int op, int v, int addr, int st, int it);
      ev_t e;
      e.kind = kind; e.op = op; e.v = v; e.addr = addr; e.st = st; e.it = it;
      return e;
   endfunction

   function automatic int code(ev_t e);
      if (e.kind == 2) return (2 << 24) | (e.st << 8) | e.it;
      return (e.kind << 24) | (e.op << 20) | (e.v << 10) | e.addr;
   endfunction

   // Reference model: walk the scripted reads and derive the commands and final status.
   task automatic predict(input int addr, input int tgt, input int rd[$]);
      int it, v, k, r, e;
      bit have, pol, p;
      it = 0; v = 0; k = 0; have = 0; pol = 0;
      expq.push_back(mk(0, 0, 0, addr, 0, 0));
      forever begin
         r = (k < rd.size()) ? rd[k] : 0;
         k++;
         e = r - tgt;
         if (e <= TOL && e >= -TOL) begin expq.push_back(mk(2, 0, 0, 0, 0, it)); return; end
         if (it == MAX_ITER)        begin expq.push_back(mk(2, 0, 0, 0, 1, it)); return; end
         p = (r < tgt);
         if (have && p == pol && v == V_MAX) begin expq.push_back(mk(2, 0, 0, 0, 2, it)); return; end
         if (!have || p != pol) v = V_START;
         else v = (v + V_STEP > V_MAX) ? V_MAX : v + V_STEP;
         have = 1; pol = p; it++;
         expq.push_back(mk(1, p, v, addr, 0, 0));
         expq.push_back(mk(0, 0, 0, addr, 0, 0));
      end
   endtask

   // Macro model: answers each command after a random delay; reads pop the scripted sequence.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (!sys_rst && work_en && !noresp) begin
            automatic bit md = work_mode;
            automatic int d = $urandom_range(0, 3) + (md ? pg_extra : 0);
            automatic int rv = 0;
            if (!md && rdq.size() > 0) rv = rdq.pop_front();
            repeat (d) @(posedge sys_clk);
            @(posedge sys_clk); #1;
            work_down = 1'b1; i_read = 8'(rv);
            @(posedge sys_clk); #1;
            work_down = 1'b0; i_read = 8'($urandom_range(0, 255));
         end
      end
   end

   initial begin
      forever begin
         @(negedge sys_clk);
         if (!sys_rst && work_en2) begin
            @(posedge sys_clk); #1 work_down2 = 1'b1;
            @(posedge sys_clk); #1 work_down2 = 1'b0;
         end
      end
   end

   always @(negedge sys_clk) if (!sys_rst && work_en2 && work_mode2) v2q.push_back(int'(v_wl2));

   // Monitor: every command strobe and every done pulse consumes one scoreboard entry.
   always @(negedge sys_clk) begin
      if (sys_rst) prev_en <= 1'b0;
      else begin
         prev_en <= work_en;
         if (work_en) begin
            automatic ev_t a = mk(work_mode ? 1 : 0, work_mode ? int'(op_mode) : 0,
                                  work_mode ? int'(v_wl) : 0, int'(addr_out), 0, 0);
            chk("we_gap", !prev_en, 1, 0);
            chk("busy_ready", busy && !req_ready, int'({busy, req_ready}), 2);
            if (!work_mode) last_rd_cyc <= cyc;
            if (expq.size() == 0) chk("unexpected_cmd", 1'b0, code(a), 0);
            else begin
               automatic ev_t e = expq.pop_front();
               chk("cmd", code(a) == code(e), code(a), code(e));
            end
         end
         if (done) begin
            automatic ev_t a = mk(2, 0, 0, 0, int'(status), int'(iter_cnt));
            if (expq.size() == 0) chk("unexpected_done", 1'b0, code(a), 0);
            else begin
               automatic ev_t e = expq.pop_front();
               chk("done", code(a) == code(e), code(a), code(e));
            end
         end
      end
   end

   task automatic run_req(input int addr, input int tgt, input int rd[$], input bit nr);
      int dcyc;
      bit got;
      rdq = rd; noresp = nr;
      if (nr) begin
         expq.push_back(mk(0, 0, 0, addr, 0, 0));
         expq.push_back(mk(2, 0, 0, 0, 3, 0));
      end else predict(addr, tgt, rd);
      @(posedge sys_clk); #1;
      req_valid = 1'b1; req_addr = 10'(addr); req_target = 8'(tgt);
      @(posedge sys_clk); #1;
      // Keep req_valid high with junk while busy; it must be ignored.
      req_addr = 10'($urandom_range(0, 1023)); req_target = 8'($urandom_range(0, 255));
      @(negedge sys_clk);
      chk("latency", work_en && !work_mode, int'(work_en), 1);
      got = 0; dcyc = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge sys_clk);
         if (done) begin got = 1; dcyc = cyc; end
      end
      req_valid = 1'b0;
      if (!got) chk("done_wait", 1'b0, 0, 1);
      if (nr) chk("timeout_lat", dcyc - last_rd_cyc == TIMEOUT, dcyc - last_rd_cyc, TIMEOUT);
      @(posedge sys_clk); #1;
      chk("sb_drained", expq.size() == 0, expq.size(), 0);
      expq.delete();
      noresp = 1'b0;
   endtask

   initial begin
      int q[$];
      int tgt, r;
      bit got;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("reset_state", req_ready && !busy && !work_en && !done && status == 0 && iter_cnt == 0
          && v_wl == 0 && addr_out == 0 && !work_mode && !op_mode, int'(req_ready), 1);

      q.delete(); q.push_back(101);
      run_req(17, 100, q, 0);
      q.delete(); q.push_back(80); q.push_back(90); q.push_back(99);
      run_req(300, 100, q, 0);
      q.delete(); q.push_back(80); q.push_back(120); q.push_back(100);
      run_req(1023, 100, q, 0);
      q.delete(); for (int i = 0; i < 20; i++) q.push_back(0);
      run_req(44, 100, q, 0);
      q.delete();
      run_req(512, 100, q, 1);

      for (int n = 0; n < 10; n++) begin
         tgt = $urandom_range(0, 255);
         q.delete();
         for (int i = 0; i < 20; i++) begin
            r = tgt + $urandom_range(0, 20) - 10;
            q.push_back(r < 0 ? 0 : (r > 255 ? 255 : r));
         end
         run_req($urandom_range(0, 1023), tgt, q, 0);
      end

      // Second instance with a low ceiling: the set ramp must stop at the ceiling.
      @(posedge sys_clk); #1 req_valid2 = 1'b1;
      @(posedge sys_clk); #1 req_valid2 = 1'b0;
      got = 0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge sys_clk);
         if (done2) got = 1;
      end
      chk("vmax_done", got && status2 == 2'b10, int'(status2), 2);
      q.delete();
      for (int v = V_START; ; v += V_STEP) begin
         q.push_back(v > V_MAX2 ? V_MAX2 : v);
         if (v >= V_MAX2) break;
      end
      chk("vmax_iter", int'(iter_cnt2) == q.size(), int'(iter_cnt2), q.size());
      chk("vmax_npulse", v2q.size() == q.size(), v2q.size(), q.size());
      for (int i = 0; i < q.size() && i < v2q.size(); i++) chk("vmax_ramp", v2q[i] == q[i], v2q[i], q[i]);

      // Reset during PG_WAIT with a late work_down still on its way.
      pg_extra = 8;
      rdq.delete(); rdq.push_back(80);
      expq.push_back(mk(0, 0, 0, 77, 0, 0));
      expq.push_back(mk(1, 1, V_START, 77, 0, 0));
      @(posedge sys_clk); #1;
      req_valid = 1'b1; req_addr = 10'd77; req_target = 8'd100;
      @(posedge sys_clk); #1 req_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge sys_clk);
         if (work_en && work_mode) got = 1;
      end
      chk("pg_reached", got, int'(got), 1);
      @(posedge sys_clk); #1;
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;
      #1;
      chk("rst_async", !work_en && !work_mode && !op_mode && !done && !busy && addr_out == 0
          && v_wl == 0 && status == 0 && iter_cnt == 0, int'({busy, work_mode, op_mode}), 0);
      @(posedge sys_clk); #1 sys_rst = 1'b0;
      expq.delete(); rdq.delete();
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (work_en || done || busy || !req_ready || addr_out != 0 || v_wl != 0
             || status != 0 || iter_cnt != 0 || work_mode || op_mode) got = 1;
      end
      chk("post_rst_quiet", !got, int'(got), 0);
      pg_extra = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mac_wv_sequencer.md
MAC_WV_SEQUENCER -- requirements
Module: mac_wv_sequencer

Interface
REQ-001 Parameters (name, default, meaning); this block SHALL provide:
- MAX_ITER, 16, maximum program pulses per request.
- TOL, 2, accepted |i_read - target| in LSB.
- V_START, 8'd40, first v_wl code of a ramp.
- V_STEP, 8'd4, v_wl increment per pulse.
- V_MAX, 8'd200, v_wl ceiling.
- TIMEOUT, 1024, cycles allowed waiting for work_down.
REQ-002 Ports (name, direction, width, meaning); one clock, reset asynchronous and active-high; this block SHALL provide:
- sys_clk, in, 1, clock, all logic on rising edge.
- sys_rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, write-verify request.
- req_ready, out, 1, block idle, request may be accepted.
- req_addr, in, 10, target cell address.
- req_target, in, 8, target read code.
- work_en, out, 1, one-cycle command strobe to the array macro.
- work_mode, out, 1, 1 = write pulse, 0 = read.
- op_mode, out, 1, 1 = set, 0 = reset.
- addr_out, out, 10, cell address to the macro.
- v_wl, out, 8, word-line voltage code.
- work_down, in, 1, macro operation complete.
- i_read, in, 8, macro read result, valid while work_down = 1.
- busy, out, 1, request in progress.
- done, out, 1, one-cycle completion pulse.
- status, out, 2, 00 pass, 01 iteration limit, 10 voltage limit, 11 timeout.
- iter_cnt, out, 5, program pulses issued for the current request.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, RD_ISSUE, RD_WAIT, CHECK, PG_ISSUE, PG_WAIT, FIN.
REQ-004 req_ready SHALL equal (state == IDLE); busy SHALL equal !req_ready.
- A request is accepted on a cycle with req_valid & req_ready.
- On acceptance, req_addr and req_target are latched, iter_cnt is cleared, the ramp flag is cleared, and the next state is RD_ISSUE.
REQ-005 req_valid SHALL be ignored in every state other than IDLE.
REQ-006 RD_ISSUE SHALL last one cycle: work_en = 1, work_mode = 0, addr_out = latched address; next state RD_WAIT.
REQ-007 addr_out, work_mode, op_mode and v_wl SHALL be registered and held stable from each ISSUE cycle until work_down is sampled.
REQ-008 In RD_WAIT, i_read SHALL be captured on the cycle work_down = 1; next state CHECK.
REQ-009 CHECK SHALL compute err = i_read - target as a 9-bit signed value; |err| <= TOL goes to FIN with status 00.
REQ-010 Otherwise, CHECK SHALL select the failure exit in this priority order (first match wins):
- iter_cnt == MAX_ITER: status 01, go to FIN.
- The previous pulse was at V_MAX with the same polarity as now required: status 10, go to FIN.
REQ-011 Otherwise, CHECK SHALL select the pulse polarity and voltage, then go to PG_ISSUE:
- Polarity: op_mode = 1 (set) if i_read < target, else 0 (reset).
- First pulse, or polarity differs from the previous pulse: v_wl = V_START.
- Same polarity as the previous pulse: v_wl = min(v_wl + V_STEP, V_MAX), computed 9-bit with no wrap.
REQ-012 PG_ISSUE SHALL last one cycle: work_en = 1, work_mode = 1; iter_cnt increments in the same cycle; next state PG_WAIT.
REQ-013 In PG_WAIT, work_down = 1 SHALL lead to RD_ISSUE (verify read).
REQ-014 A per-wait counter SHALL clear on each ISSUE cycle.
- If TIMEOUT cycles elapse in RD_WAIT or PG_WAIT without work_down, the next state is FIN with status 11.
- work_down arriving on the same cycle as the timeout wins: normal progression, no timeout.
REQ-015 FIN SHALL assert done for exactly one cycle, then return to IDLE.
- status and iter_cnt hold their values until the next request is accepted.
REQ-016 work_down SHALL be ignored in IDLE, CHECK, FIN and the ISSUE states.
REQ-017 work_en SHALL never be high on two consecutive cycles.
REQ-018 Request-to-first-work_en latency SHALL be exactly 1 cycle.

Reset
REQ-019 sys_rst = 1 SHALL immediately force these values, including mid-operation:
- State IDLE.
- work_en, work_mode, op_mode, done, busy = 0.
- addr_out = 0, v_wl = 0, status = 00, iter_cnt = 0.
- req_ready = 1 after reset is released.
REQ-020 A work_down arriving after a reset SHALL NOT cause any output change.

Verification
REQ-021 target = 100, model returns i_read = 101 on the first read -> one read, no pulse, done with status 00, iter_cnt = 0.
REQ-022 target = 100, model reads 80, 90, then 99, with each set pulse raising the read result -> pulses issued:
- Set at v_wl = 40, then set at v_wl = 44.
- Result: status 00, iter_cnt = 2.
REQ-023 target = 100, model reads 80, then 120, then 100 -> pulses issued:
- Set at v_wl = 40, then reset at v_wl = 40 (polarity change restarts the ramp).
- Result: status 00.
REQ-024 Model never changes i_read = 0 -> set ramp 40, 44, ... clamped at 200; expected termination:
- With V_MAX = 60: status 10 after the pulse at 60.
- With defaults: status 01, iter_cnt = 16.
REQ-025 Model never asserts work_down -> done with status 11 exactly TIMEOUT cycles after the read issue.
REQ-026 Assert sys_rst while in PG_WAIT, then deliver work_down -> all outputs at reset values, no work_en and no done.
